// File: rtl/rx_word_aligner.sv
// rx_word_aligner
//
// Fabric-side receive word aligner placed directly behind an I_SERDES. During link
// training the far end sends a fixed training word; this block compares each valid
// deserialized word against that pattern and pulses BITSLIP_ADJ until the word
// boundary lines up. It then passes the aligned data through and reports lock, or
// failure once the slip budget is spent.
//
// Parameters:
//   WIDTH          deserialization width, same as the I_SERDES WIDTH (3-10)
//   TRAIN_PATTERN  training word; only bits [WIDTH-1:0] are compared. All WIDTH
//                  rotations of it must be distinct.
//   MATCH_COUNT    consecutive matching valid words needed for lock (1-255)
//   SLIP_WAIT      valid words discarded after each bitslip pulse (1-15)
//   MAX_SLIPS      bitslip attempts allowed before failure (1-31)
//
// Ports:
//   CLK_IN          fabric clock (I_SERDES CLK_OUT domain)
//   RST             asynchronous active-low reset
//   PLL_LOCK        PLL/DPA lock; low returns the aligner to idle
//   ALIGN_START     single-cycle request to start or restart alignment
//   Q, DATA_VALID   word from the I_SERDES and its qualifier
//   BITSLIP_ADJ     one-cycle pulse per slip, to the I_SERDES
//   Q_OUT           Q delayed by one cycle
//   DATA_VALID_OUT  DATA_VALID delayed by one cycle, only while locked
//   ALIGN_DONE      level, high while locked
//   ALIGN_FAIL      level, high while failed
//   SLIP_COUNT      slips issued since the last start
//   ALIGN_CYCLES    (RX_ALIGN_STATS_EN only) cycles spent aligning, saturating
//
// Optional feature macro: RX_ALIGN_STATS_EN adds the ALIGN_CYCLES statistics output.

module rx_word_aligner #(
  parameter int unsigned WIDTH         = 4,
  parameter logic [9:0]  TRAIN_PATTERN = 10'b0000001100,
  parameter int unsigned MATCH_COUNT   = 8,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned MAX_SLIPS     = 8
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             PLL_LOCK,
  input  logic             ALIGN_START,
  input  logic [WIDTH-1:0] Q,
  input  logic             DATA_VALID,
  output logic             BITSLIP_ADJ,
  output logic [WIDTH-1:0] Q_OUT,
  output logic             DATA_VALID_OUT,
  output logic             ALIGN_DONE,
  output logic             ALIGN_FAIL,
  output logic [4:0]       SLIP_COUNT
`ifdef RX_ALIGN_STATS_EN
  ,
  output logic [15:0]      ALIGN_CYCLES
`endif
);

  localparam logic [WIDTH-1:0] Pattern  = TRAIN_PATTERN[WIDTH-1:0];
  localparam logic [7:0]       MatchMax = 8'(MATCH_COUNT);
  localparam logic [3:0]       WaitMax  = 4'(SLIP_WAIT);
  localparam logic [4:0]       SlipMax  = 5'(MAX_SLIPS);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSlip,
    StWait,
    StLocked,
    StFail
  } state_e;

  state_e     state_q;
  logic [7:0] match_cnt_q;
  logic [3:0] wait_cnt_q;

  // Control FSM. All outputs are registered alongside the state so that ALIGN_DONE,
  // ALIGN_FAIL and BITSLIP_ADJ are exact images of LOCKED, FAIL and SLIP.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state_q        <= StIdle;
      match_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      BITSLIP_ADJ    <= 1'b0;
      Q_OUT          <= '0;
      DATA_VALID_OUT <= 1'b0;
      ALIGN_DONE     <= 1'b0;
      ALIGN_FAIL     <= 1'b0;
      SLIP_COUNT     <= '0;
    end else begin
      Q_OUT          <= Q;
      // Uses the current state: the first word after lock is not yet flagged valid.
      DATA_VALID_OUT <= DATA_VALID & (state_q == StLocked);
      BITSLIP_ADJ    <= 1'b0;

      if (!PLL_LOCK) begin
        // Loss of lock beats everything, including a pending start request.
        state_q     <= StIdle;
        match_cnt_q <= '0;
        wait_cnt_q  <= '0;
        ALIGN_DONE  <= 1'b0;
        ALIGN_FAIL  <= 1'b0;
        SLIP_COUNT  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ALIGN_START) begin
              state_q     <= StCheck;
              match_cnt_q <= '0;
              SLIP_COUNT  <= '0;
            end
          end

          StCheck: begin
            if (DATA_VALID) begin
              if (Q == Pattern) begin
                if (match_cnt_q == MatchMax - 8'd1) begin
                  state_q     <= StLocked;
                  match_cnt_q <= MatchMax;
                  ALIGN_DONE  <= 1'b1;
                end else begin
                  match_cnt_q <= match_cnt_q + 8'd1;
                end
              end else begin
                match_cnt_q <= '0;
                if (SLIP_COUNT == SlipMax) begin
                  state_q    <= StFail;
                  ALIGN_FAIL <= 1'b1;
                end else begin
                  // Pulse and count are raised on entry so they are valid during SLIP.
                  state_q     <= StSlip;
                  BITSLIP_ADJ <= 1'b1;
                  SLIP_COUNT  <= SLIP_COUNT + 5'd1;
                end
              end
            end
          end

          StSlip: begin
            state_q    <= StWait;
            wait_cnt_q <= '0;
          end

          StWait: begin
            // Words here straddle the old and new boundary, so they are only counted.
            if (DATA_VALID) begin
              if (wait_cnt_q == WaitMax - 4'd1) begin
                state_q     <= StCheck;
                wait_cnt_q  <= '0;
                match_cnt_q <= '0;
              end else begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
              end
            end
          end

          StLocked: begin
            if (ALIGN_START) begin
              state_q     <= StCheck;
              match_cnt_q <= '0;
              ALIGN_DONE  <= 1'b0;
              SLIP_COUNT  <= '0;
            end
          end

          StFail: begin
            if (ALIGN_START) begin
              state_q     <= StCheck;
              match_cnt_q <= '0;
              ALIGN_FAIL  <= 1'b0;
              SLIP_COUNT  <= '0;
            end
          end

          default: begin
            state_q     <= StIdle;
            match_cnt_q <= '0;
            wait_cnt_q  <= '0;
            ALIGN_DONE  <= 1'b0;
            ALIGN_FAIL  <= 1'b0;
            SLIP_COUNT  <= '0;
          end
        endcase
      end
    end
  end

`ifdef RX_ALIGN_STATS_EN
  // Time spent searching for the boundary; frozen once the outcome is known.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      ALIGN_CYCLES <= '0;
    end else if (!PLL_LOCK) begin
      ALIGN_CYCLES <= '0;
    end else begin
      unique case (state_q)
        StCheck, StSlip, StWait: begin
          if (ALIGN_CYCLES != 16'hFFFF) begin
            ALIGN_CYCLES <= ALIGN_CYCLES + 16'd1;
          end
        end
        StLocked, StFail: begin
          if (ALIGN_START) begin
            ALIGN_CYCLES <= '0;
          end
        end
        default: ALIGN_CYCLES <= '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rx_word_aligner.sv
// Testbench for rx_word_aligner. An I_SERDES stand-in rotates the source word left by
// one position per BITSLIP_ADJ pulse. The reference model works on whole words: it
// keeps the valid words seen since the last start or slip and applies the lock, slip
// and fail rules to that list to predict every output cycle by cycle.

module tb_rx_word_aligner;

  localparam int          W     = 4;
  localparam logic [3:0]  PAT   = 4'b1100;
  localparam int          MATCH = 8;
  localparam int          SWAIT = 4;
  localparam int          MAXS  = 8;

  logic       CLK_IN      = 1'b0;
  logic       RST         = 1'b0;
  logic       PLL_LOCK    = 1'b0;
  logic       ALIGN_START = 1'b0;
  logic [3:0] Q           = '0;
  logic       DATA_VALID  = 1'b0;
  logic       BITSLIP_ADJ;
  logic [3:0] Q_OUT;
  logic       DATA_VALID_OUT;
  logic       ALIGN_DONE;
  logic       ALIGN_FAIL;
  logic [4:0] SLIP_COUNT;
`ifdef RX_ALIGN_STATS_EN
  logic [15:0] ALIGN_CYCLES;
`endif

  rx_word_aligner #(
    .WIDTH        (W),
    .TRAIN_PATTERN(10'b0000001100),
    .MATCH_COUNT  (MATCH),
    .SLIP_WAIT    (SWAIT),
    .MAX_SLIPS    (MAXS)
  ) dut (
    .CLK_IN        (CLK_IN),
    .RST           (RST),
    .PLL_LOCK      (PLL_LOCK),
    .ALIGN_START   (ALIGN_START),
    .Q             (Q),
    .DATA_VALID    (DATA_VALID),
    .BITSLIP_ADJ   (BITSLIP_ADJ),
    .Q_OUT         (Q_OUT),
    .DATA_VALID_OUT(DATA_VALID_OUT),
    .ALIGN_DONE    (ALIGN_DONE),
    .ALIGN_FAIL    (ALIGN_FAIL),
    .SLIP_COUNT    (SLIP_COUNT)
`ifdef RX_ALIGN_STATS_EN
    ,
    .ALIGN_CYCLES  (ALIGN_CYCLES)
`endif
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // I_SERDES stand-in
  logic [3:0] src_word = PAT;
  int         rot      = 0;

  function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
    logic [3:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  // Reference model
  typedef enum int {MIdle, MAlign, MLocked, MFail} mode_e;
  mode_e      m_mode;
  int         m_slips;
  int         m_cycles;
  logic [3:0] m_words[$];
  bit         m_waiting;
  bit         m_skip;
  int         cyc        = 0;
  int         last_pulse = -1;

  task automatic model_reset();
    m_mode    = MIdle;
    m_slips   = 0;
    m_cycles  = 0;
    m_words.delete();
    m_waiting = 1'b0;
    m_skip    = 1'b0;
    last_pulse = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bitslip"}, BITSLIP_ADJ, 0);
    check_eq({tag, "_q_out"}, Q_OUT, 0);
    check_eq({tag, "_dvo"}, DATA_VALID_OUT, 0);
    check_eq({tag, "_done"}, ALIGN_DONE, 0);
    check_eq({tag, "_fail"}, ALIGN_FAIL, 0);
    check_eq({tag, "_slips"}, SLIP_COUNT, 0);
`ifdef RX_ALIGN_STATS_EN
    check_eq({tag, "_cycles"}, ALIGN_CYCLES, 0);
`endif
  endtask

  // One clock: drive at the falling edge, let the rising edge happen, check at the next
  // falling edge.
  task automatic cycle(input bit start, input bit pll, input bit dv, input bit inj,
                       input logic [3:0] inj_word);
    logic [3:0] w;
    bit         exp_pulse;
    bit         exp_dvo;
    int         base;
    w = inj ? inj_word : rotl(src_word, rot);
    ALIGN_START = start;
    PLL_LOCK    = pll;
    DATA_VALID  = dv;
    Q           = w;

    exp_pulse = 1'b0;
    exp_dvo   = dv && (m_mode == MLocked);
    if (pll && m_mode == MAlign && m_cycles < 65535) m_cycles++;
    if (!pll) begin
      m_mode     = MIdle;
      m_slips    = 0;
      m_cycles   = 0;
      last_pulse = -1;
    end else if (start && m_mode != MAlign) begin
      m_mode     = MAlign;
      m_slips    = 0;
      m_cycles   = 0;
      m_words.delete();
      m_waiting  = 1'b0;
      m_skip     = 1'b0;
      last_pulse = -1;
    end else if (m_mode == MAlign) begin
      if (m_skip) begin
        m_skip = 1'b0;  // word arriving while the slip pulse is out
      end else if (dv) begin
        m_words.push_back(w);
        base = m_waiting ? SWAIT : 0;
        if (m_words.size() > base) begin
          if (w != PAT) begin
            if (m_slips == MAXS) begin
              m_mode = MFail;
            end else begin
              exp_pulse = 1'b1;
              m_slips++;
              m_words.delete();
              m_waiting = 1'b1;
              m_skip    = 1'b1;
            end
          end else if (m_words.size() - base == MATCH) begin
            m_mode = MLocked;
          end
        end
      end
    end

    @(posedge CLK_IN);
    @(negedge CLK_IN);
    cyc++;
    check_eq("bitslip", BITSLIP_ADJ, exp_pulse);
    check_eq("align_done", ALIGN_DONE, m_mode == MLocked);
    check_eq("align_fail", ALIGN_FAIL, m_mode == MFail);
    check_eq("slip_count", SLIP_COUNT, m_slips);
    check_eq("data_valid_out", DATA_VALID_OUT, exp_dvo);
    check_eq("q_out", Q_OUT, w);
`ifdef RX_ALIGN_STATS_EN
    check_eq("align_cycles", ALIGN_CYCLES, m_cycles);
`endif
    if (BITSLIP_ADJ) begin
      if (last_pulse >= 0) check_eq("slip_gap_ok", (cyc - last_pulse) >= SWAIT + 1, 1);
      last_pulse = cyc;
      rot = (rot + 1) % 4;
    end
  endtask

  task automatic run_align(input logic [3:0] src, input int r, input int dens);
    src_word = src;
    rot      = r;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 400 && m_mode == MAlign; i++) begin
      cycle($urandom_range(0, 15) == 0, 1'b1, $urandom_range(1, dens) == 1, 1'b0, 4'h0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b0, 4'h0);
  endtask

  initial begin
    int nv;
    bit v;
    model_reset();
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    check_all_zero("reset");
    RST      = 1'b1;
    PLL_LOCK = 1'b1;

    // Already aligned, then offset of two rotations, DATA_VALID every cycle.
    run_align(PAT, 0, 1);
    run_align(PAT, 2, 1);

    // Constant zero word: slip budget exhausted, then a restart that succeeds.
    run_align(4'b0000, 0, 1);
    run_align(PAT, 1, 2);

    // DATA_VALID every third cycle with one corrupted word at valid word 5.
    src_word = PAT;
    rot      = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    nv = 0;
    for (int i = 1; i < 300 && m_mode == MAlign; i++) begin
      v = (i % 3 == 0);
      if (v) nv++;
      cycle(1'b0, 1'b1, v, v && nv == 5, 4'b0110);
    end

    // PLL_LOCK lost during WAIT; a start request while unlocked does nothing.
    src_word = PAT;
    rot      = 1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 50 && !(m_waiting && !m_skip); i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    run_align(PAT, 3, 1);

    // Randomized trials.
    for (int t = 0; t < 10; t++) begin
      run_align(($urandom_range(0, 4) == 0) ? 4'b0000 : PAT, $urandom_range(0, 3),
                $urandom_range(1, 3));
    end

    // Asynchronous reset while locked, asserted between clock edges.
    run_align(PAT, 2, 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    #2 RST = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge CLK_IN);
    check_all_zero("reset_held");
    RST = 1'b1;
    model_reset();
    run_align(PAT, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
